// File: rtl/rs_excitation_driver.sv
// -----------------------------------------------------------------------------
// rs_excitation_driver
//
// Writer-side companion for the clocked RS flip-flop (S, R, CLK, Q, QB).
// Target Q bits arrive over a valid/ready handshake and are buffered in a small
// circular FIFO. Each target is turned into a legal S/R excitation based on the
// tracked flop state (Q_MODEL). The excitation is driven for one cycle, and the
// Q/QB feedback is then checked. A mismatch sets a sticky ERR flag and bumps a
// saturating ERR_CNT.
//
// Ports
//   CLK       in   clock, rising edge
//   RST       in   synchronous active-high reset
//   IN_VALID  in   target bit offered
//   IN_BIT    in   target Q value
//   IN_READY  out  FIFO can take a bit this cycle
//   S, R      out  registered set/reset commands to the flop (never both 1)
//   Q_FB      in   flop Q
//   QB_FB     in   flop QB
//   Q_MODEL   out  tracked (expected) flop state
//   BUSY      out  FSM not IDLE or FIFO not empty
//   CHK_DONE  out  one-cycle pulse per completed check
//   ERR       out  sticky mismatch flag
//   ERR_CNT   out  saturating mismatch count
//
// Handshake: a bit transfers on a rising edge where IN_VALID and IN_READY are
// both high. IN_READY does not depend on IN_VALID. It is low during reset. It
// is also low while the FIFO is full, except in a cycle where the FSM pops the
// head, because then a simultaneous push fits.
//
// Debug: r_state holds the current FSM state (state_t) for checkers to bind to.
// -----------------------------------------------------------------------------
module rs_excitation_driver #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic             IN_BIT,
  output logic             IN_READY,
  output logic             S,
  output logic             R,
  input  logic             Q_FB,
  input  logic             QB_FB,
  output logic             Q_MODEL,
  output logic             BUSY,
  output logic             CHK_DONE,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK
  } state_t;

  // FSM and datapath registers
  state_t           r_state;
  logic             r_s;
  logic             r_r;
  logic             r_target;
  logic             r_q_model;
  logic             r_old_q;
  logic             r_init_chk;   // current check belongs to the INIT force-to-0
  logic             r_chk_done;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;

  // FIFO registers
  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Next-state / combinational signals
  state_t           w_state_nxt;
  logic             w_s_nxt;
  logic             w_r_nxt;
  logic             w_target_nxt;
  logic             w_q_model_nxt;
  logic             w_old_q_nxt;
  logic             w_init_chk_nxt;
  logic             w_chk_done_nxt;
  logic             w_err_nxt;
  logic [ERR_W-1:0] w_err_cnt_nxt;
  logic             w_mismatch;

  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic             w_pop;
  logic             w_push;
  logic             w_head;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == FULL_CNT);
  assign w_head       = r_mem[r_rd_ptr];

  // The FSM takes a new target only in IDLE or at the end of a CHECK.
  assign w_pop    = !w_fifo_empty && ((r_state == ST_IDLE) || (r_state == ST_CHECK));
  assign IN_READY = !RST && (!w_fifo_full || w_pop);
  assign w_push   = IN_VALID && IN_READY;

  // ---------------------------------------------------------------------------
  // FSM: next state and next register values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_s_nxt        = 1'b0;
    w_r_nxt        = 1'b0;
    w_target_nxt   = r_target;
    w_q_model_nxt  = r_q_model;
    w_old_q_nxt    = r_old_q;
    w_init_chk_nxt = r_init_chk;
    w_chk_done_nxt = 1'b0;
    w_err_nxt      = r_err;
    w_err_cnt_nxt  = r_err_cnt;
    w_mismatch     = 1'b0;

    case (r_state)
      ST_INIT: begin
        // The flop's power-up state is unknown, so force it to 0 through the
        // normal WAIT/CHECK path.
        w_r_nxt        = 1'b1;
        w_target_nxt   = 1'b0;
        w_init_chk_nxt = 1'b1;
        w_state_nxt    = ST_WAIT;
      end

      ST_IDLE: begin
        if (w_pop) begin
          w_target_nxt   = w_head;
          w_init_chk_nxt = 1'b0;
          w_state_nxt    = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        // Excitation only on a change; equal target holds with S=R=0.
        if (r_target && !r_q_model) begin
          w_s_nxt = 1'b1;
        end else if (!r_target && r_q_model) begin
          w_r_nxt = 1'b1;
        end
        w_state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        // The flop samples S/R at this edge; the model follows the target.
        w_old_q_nxt   = r_q_model;
        w_q_model_nxt = r_target;
        w_state_nxt   = ST_CHECK;
      end

      ST_CHECK: begin
        // QB lags Q by one flop update, so it should show the inverse of the
        // state before this transition. After INIT that state is unknown.
        w_mismatch = (Q_FB != r_target) ||
                     (!r_init_chk && (QB_FB != ~r_old_q));
        w_chk_done_nxt = 1'b1;
        if (w_mismatch) begin
          w_err_nxt = 1'b1;
          if (r_err_cnt != '1) begin
            w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
          end
        end
        w_init_chk_nxt = 1'b0;
        if (w_pop) begin
          w_target_nxt = w_head;
          w_state_nxt  = ST_DRIVE;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_INIT;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_target   <= 1'b0;
      r_q_model  <= 1'b0;
      r_old_q    <= 1'b0;
      r_init_chk <= 1'b0;
      r_chk_done <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_s        <= w_s_nxt;
      r_r        <= w_r_nxt;
      r_target   <= w_target_nxt;
      r_q_model  <= w_q_model_nxt;
      r_old_q    <= w_old_q_nxt;
      r_init_chk <= w_init_chk_nxt;
      r_chk_done <= w_chk_done_nxt;
      r_err      <= w_err_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Target FIFO: circular buffer; pointers wrap naturally (DEPTH is 2^AW)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= IN_BIT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign S        = r_s;
  assign R        = r_r;
  assign Q_MODEL  = r_q_model;
  assign CHK_DONE = r_chk_done;
  assign ERR      = r_err;
  assign ERR_CNT  = r_err_cnt;
  assign BUSY     = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule
